// File: rtl/alien_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alien_march_ctrl
// Purpose  : Space Invaders formation march controller. A rate divider
//            produces one-cycle move_tick strobes; each strobe steps the
//            formation origin horizontally, or drops it one row and reverses
//            direction at a side edge. Every alien hit shortens the step
//            period down to a floor. Once the formation reaches Y_MAX it
//            lands and freezes until reset.
// Ports    : CLK        in   system clock
//            Rst        in   synchronous active-high reset
//            EN         in   march enable; low freezes divider and position
//            hit_pulse  in   one-cycle strobe per alien destroyed
//            move_tick  out  one-cycle strobe per step
//            pos_x      out  formation X origin (11 bit)
//            pos_y      out  formation Y origin (11 bit)
//            dir        out  0 = moving right, 1 = moving left
//            drop       out  one-cycle strobe on edge-reversal steps
//            landed     out  level, formation has reached Y_MAX
// Revision : 1.0 - initial release
// ============================================================================
module alien_march_ctrl #(
    parameter int DIV_W     = 24,
    parameter int TICK_DIV  = 2000000,
    parameter int MIN_DIV   = 250000,
    parameter int SPEED_DEC = 25000,
    parameter int X_START   = 80,
    parameter int Y_START   = 40,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 480,
    parameter int STEP_X    = 8,
    parameter int STEP_Y    = 16,
    parameter int Y_MAX     = 400
) (
    input  logic        CLK,
    input  logic        Rst,
    input  logic        EN,
    input  logic        hit_pulse,
    output logic        move_tick,
    output logic [10:0] pos_x,
    output logic [10:0] pos_y,
    output logic        dir,
    output logic        drop,
    output logic        landed
);

    typedef enum logic [1:0] {
        S_RIGHT  = 2'd0,
        S_LEFT   = 2'd1,
        S_LANDED = 2'd2
    } state_t;

    // Period arithmetic is carried one bit wider so that subtraction and the
    // floor test never wrap.
    localparam logic [DIV_W-1:0] c_tick_div  = DIV_W'(TICK_DIV);
    localparam logic [DIV_W:0]   c_min_div   = (DIV_W+1)'(MIN_DIV);
    localparam logic [DIV_W:0]   c_speed_dec = (DIV_W+1)'(SPEED_DEC);
    localparam logic [DIV_W:0]   c_dec_floor = c_min_div + c_speed_dec;

    // Position edge tests are evaluated at 12 bits to avoid underflow/overflow.
    localparam logic [11:0] c_x_max   = 12'(X_MAX);
    localparam logic [11:0] c_x_left  = 12'(X_MIN + STEP_X);
    localparam logic [11:0] c_y_max   = 12'(Y_MAX);
    localparam logic [11:0] c_step_x  = 12'(STEP_X);
    localparam logic [11:0] c_step_y  = 12'(STEP_Y);
    localparam logic [10:0] c_x_start = 11'(X_START);
    localparam logic [10:0] c_y_start = 11'(Y_START);

    state_t             r_state,     w_state_nxt;
    logic [DIV_W-1:0]   r_div_cnt,   w_div_cnt_nxt;
    logic [DIV_W-1:0]   r_period,    w_period_nxt;
    logic [10:0]        r_pos_x,     w_pos_x_nxt;
    logic [10:0]        r_pos_y,     w_pos_y_nxt;
    logic               r_dir,       w_dir_nxt;
    logic               r_move_tick, w_move_tick_nxt;
    logic               r_drop,      w_drop_nxt;
    logic               r_landed,    w_landed_nxt;

    logic               w_run;
    logic               w_expire;
    logic [11:0]        w_x_ext;
    logic [11:0]        w_y_drop;
    logic [DIV_W:0]     w_period_ext;

    always_ff @(posedge CLK) begin
        if (Rst) begin
            r_state     <= S_RIGHT;
            r_div_cnt   <= '0;
            r_period    <= c_tick_div;
            r_pos_x     <= c_x_start;
            r_pos_y     <= c_y_start;
            r_dir       <= 1'b0;
            r_move_tick <= 1'b0;
            r_drop      <= 1'b0;
            r_landed    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_cnt_nxt;
            r_period    <= w_period_nxt;
            r_pos_x     <= w_pos_x_nxt;
            r_pos_y     <= w_pos_y_nxt;
            r_dir       <= w_dir_nxt;
            r_move_tick <= w_move_tick_nxt;
            r_drop      <= w_drop_nxt;
            r_landed    <= w_landed_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_div_cnt_nxt   = r_div_cnt;
        w_period_nxt    = r_period;
        w_pos_x_nxt     = r_pos_x;
        w_pos_y_nxt     = r_pos_y;
        w_dir_nxt       = r_dir;
        w_move_tick_nxt = 1'b0;
        w_drop_nxt      = 1'b0;
        w_landed_nxt    = r_landed;

        w_run        = EN && (r_state != S_LANDED);
        // div_cnt >= period-1, written as div_cnt+1 >= period so period=0
        // cannot wrap.
        w_expire     = ({1'b0, r_div_cnt} + 1'b1) >= {1'b0, r_period};
        w_x_ext      = {1'b0, r_pos_x};
        w_y_drop     = {1'b0, r_pos_y} + c_step_y;
        w_period_ext = {1'b0, r_period};

        if (w_run) begin
            if (w_expire) begin
                w_div_cnt_nxt   = '0;
                w_move_tick_nxt = 1'b1;
                case (r_state)
                    S_RIGHT: begin
                        if (w_x_ext + c_step_x > c_x_max) begin
                            w_pos_y_nxt = w_y_drop[10:0];
                            w_dir_nxt   = 1'b1;
                            w_state_nxt = S_LEFT;
                            w_drop_nxt  = 1'b1;
                        end else begin
                            w_pos_x_nxt = r_pos_x + c_step_x[10:0];
                        end
                    end
                    S_LEFT: begin
                        if (w_x_ext < c_x_left) begin
                            w_pos_y_nxt = w_y_drop[10:0];
                            w_dir_nxt   = 1'b0;
                            w_state_nxt = S_RIGHT;
                            w_drop_nxt  = 1'b1;
                        end else begin
                            w_pos_x_nxt = r_pos_x - c_step_x[10:0];
                        end
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
                // A drop that reaches the bottom lands on the same edge.
                if (w_drop_nxt && (w_y_drop >= c_y_max)) begin
                    w_state_nxt  = S_LANDED;
                    w_landed_nxt = 1'b1;
                end
            end else begin
                w_div_cnt_nxt = r_div_cnt + 1'b1;
            end
        end

        // The step above already used the old period; a coincident hit only
        // affects the next interval.
        if (hit_pulse && (r_state != S_LANDED)) begin
            if (w_period_ext >= c_dec_floor) begin
                w_period_nxt = r_period - c_speed_dec[DIV_W-1:0];
            end else begin
                w_period_nxt = c_min_div[DIV_W-1:0];
            end
        end
    end

    assign move_tick = r_move_tick;
    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign dir       = r_dir;
    assign drop      = r_drop;
    assign landed    = r_landed;

endmodule
`default_nettype wire

// File: tb/tb_alien_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alien_march_ctrl
// Purpose  : Self-checking bench for alien_march_ctrl using a table of
//            {inputs, cycle count, expected outputs} records. Each record
//            drives its inputs for n edges; the edges before the last must
//            show no move_tick/drop, and the outputs after the last edge are
//            compared against the record's expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alien_march_ctrl;

    logic        CLK = 1'b0;
    logic        Rst = 1'b1;
    logic        EN = 1'b0;
    logic        hit_pulse = 1'b0;
    logic        move_tick;
    logic [10:0] pos_x;
    logic [10:0] pos_y;
    logic        dir;
    logic        drop;
    logic        landed;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alien_march_ctrl #(
        .DIV_W     (24),
        .TICK_DIV  (4),
        .MIN_DIV   (2),
        .SPEED_DEC (1),
        .X_START   (0),
        .Y_START   (0),
        .X_MIN     (0),
        .X_MAX     (16),
        .STEP_X    (8),
        .STEP_Y    (8),
        .Y_MAX     (24)
    ) dut (
        .CLK       (CLK),
        .Rst       (Rst),
        .EN        (EN),
        .hit_pulse (hit_pulse),
        .move_tick (move_tick),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .dir       (dir),
        .drop      (drop),
        .landed    (landed)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        hit;
        int          n;
        logic        mt;
        logic        dr;
        logic        ld;
        logic        dir;
        logic [10:0] x;
        logic [10:0] y;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic h, input int n,
                       input logic mt, input logic dr, input logic ld,
                       input logic d, input int x, input int y);
        vec_t v;
        v.rst = r; v.en = e; v.hit = h; v.n = n;
        v.mt = mt; v.dr = dr; v.ld = ld; v.dir = d;
        v.x = 11'(x); v.y = 11'(y);
        vecs.push_back(v);
    endtask

    initial begin
        logic [25:0] act;
        logic [25:0] exp;

        //    rst en hit  n  mt dr ld dir  x   y
        // Scenarios 1-3: reset, march right, drop, left, drop, right, land
        add(1, 0, 0,  2, 0, 0, 0, 0,  0,  0);
        add(0, 1, 0,  3, 0, 0, 0, 0,  0,  0);
        add(0, 1, 0,  1, 1, 0, 0, 0,  8,  0);
        add(0, 1, 0,  4, 1, 0, 0, 0, 16,  0);
        add(0, 1, 0,  4, 1, 1, 0, 1, 16,  8);
        add(0, 1, 0,  4, 1, 0, 0, 1,  8,  8);
        add(0, 1, 0,  4, 1, 0, 0, 1,  0,  8);
        add(0, 1, 0,  4, 1, 1, 0, 0,  0, 16);
        add(0, 1, 0,  4, 1, 0, 0, 0,  8, 16);
        add(0, 1, 0,  4, 1, 0, 0, 0, 16, 16);
        add(0, 1, 0,  4, 1, 1, 1, 1, 16, 24);
        add(0, 1, 1, 20, 0, 0, 1, 1, 16, 24);
        // Scenario 6a: reset from LANDED, first step 4 enabled edges later
        add(1, 1, 0,  1, 0, 0, 0, 0,  0,  0);
        add(0, 1, 0,  3, 0, 0, 0, 0,  0,  0);
        add(0, 1, 0,  1, 1, 0, 0, 0,  8,  0);
        // Scenario 4: freeze for 10 cycles with two counts still to go
        add(0, 1, 0,  2, 0, 0, 0, 0,  8,  0);
        add(0, 0, 0, 10, 0, 0, 0, 0,  8,  0);
        add(0, 1, 0,  1, 0, 0, 0, 0,  8,  0);
        add(0, 1, 0,  1, 1, 0, 0, 0, 16,  0);
        // Scenario 6b: reset mid-interval
        add(0, 1, 0,  2, 0, 0, 0, 0, 16,  0);
        add(1, 1, 0,  1, 0, 0, 0, 0,  0,  0);
        add(0, 1, 0,  3, 0, 0, 0, 0,  0,  0);
        add(0, 1, 0,  1, 1, 0, 0, 0,  8,  0);
        // Scenario 5: hits shrink period 4 -> 3 -> 2 -> 2 (floor)
        add(0, 1, 1,  1, 0, 0, 0, 0,  8,  0);
        add(0, 1, 0,  1, 0, 0, 0, 0,  8,  0);
        add(0, 1, 0,  1, 1, 0, 0, 0, 16,  0);
        add(0, 1, 0,  2, 0, 0, 0, 0, 16,  0);
        add(0, 1, 0,  1, 1, 1, 0, 1, 16,  8);
        add(0, 1, 1,  1, 0, 0, 0, 1, 16,  8);
        add(0, 1, 0,  1, 1, 0, 0, 1,  8,  8);
        add(0, 1, 0,  1, 0, 0, 0, 1,  8,  8);
        add(0, 1, 0,  1, 1, 0, 0, 1,  0,  8);
        add(0, 1, 1,  1, 0, 0, 0, 1,  0,  8);
        add(0, 1, 0,  1, 1, 1, 0, 0,  0, 16);
        // Hit during reset is ignored; hit coincident with a step keeps the
        // old interval and shortens the following one to 3.
        add(1, 1, 1,  1, 0, 0, 0, 0,  0,  0);
        add(0, 1, 0,  3, 0, 0, 0, 0,  0,  0);
        add(0, 1, 1,  1, 1, 0, 0, 0,  8,  0);
        add(0, 1, 0,  2, 0, 0, 0, 0,  8,  0);
        add(0, 1, 0,  1, 1, 0, 0, 0, 16,  0);

        @(negedge CLK);
        for (int i = 0; i < vecs.size(); i++) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                Rst       = vecs[i].rst;
                EN        = vecs[i].en;
                hit_pulse = vecs[i].hit;
                @(posedge CLK);
                #1;
                if (c < vecs[i].n - 1) begin
                    checks++;
                    if (move_tick !== 1'b0 || drop !== 1'b0) begin
                        errors++;
                        $display("FAIL quiet vec=%0d cyc=%0d: move_tick=%b drop=%b, required 0 0",
                                 i, c, move_tick, drop);
                    end
                end
            end
            act = {move_tick, drop, landed, dir, pos_x, pos_y};
            exp = {vecs[i].mt, vecs[i].dr, vecs[i].ld, vecs[i].dir, vecs[i].x, vecs[i].y};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL vec=%0d: got mt=%b drop=%b landed=%b dir=%b x=%0d y=%0d, required mt=%b drop=%b landed=%b dir=%b x=%0d y=%0d",
                         i, move_tick, drop, landed, dir, pos_x, pos_y,
                         exp[25], exp[24], exp[23], exp[22], exp[21:11], exp[10:0]);
            end
        end

        Rst       = 1'b0;
        EN        = 1'b0;
        hit_pulse = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
